// File: rtl/mac_window_requant.sv
// Window-sum extraction, int8 requantization and output FIFO for the MAC stream.
// Optional: define MAC_REQUANT_RELU_EN to clamp negative results to zero.
module mac_window_requant #(
    parameter int VEC_LEN = 16,
    parameter int SHIFT   = 4,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] acc_in,
    input  logic        acc_step,
    input  logic        sync_clr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic signed [16:0] RND = 17'(1 << (SHIFT - 1));

    // Elaboration-time parameter sanity
    generate
        if (VEC_LEN < 1) begin : g_bad_vec
            $error("VEC_LEN must be >= 1");
        end
        if (SHIFT < 1 || SHIFT > 8) begin : g_bad_shift
            $error("SHIFT must be in 1..8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    // ------------------------------------------------------------
    // Window tracking
    // ------------------------------------------------------------
    logic [CW-1:0] count;
    logic [15:0]   base;
    logic          done;

    // A clear cycle never completes a window, even with a step
    assign done = acc_step & ~sync_clr & (count == LAST);

    // Count accumulator steps inside the current window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (sync_clr) begin
            count <= '0;
        end else if (acc_step) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

    // Snapshot the accumulator at every window boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base <= '0;
        end else if (sync_clr || done) begin
            base <= acc_in;
        end
    end

    // ------------------------------------------------------------
    // Stage 1: modular window difference
    // ------------------------------------------------------------
    logic [15:0] delta;
    logic        d_vld;

    // Wrap-around of the accumulator cancels out in the 16-bit difference
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delta <= '0;
            d_vld <= 1'b0;
        end else begin
            d_vld <= done;
            if (done) begin
                delta <= acc_in - base;
            end
        end
    end

    // ------------------------------------------------------------
    // Stage 2: round half up, shift, saturate (combinational into FIFO)
    // ------------------------------------------------------------
    logic signed [16:0] r_sum;
    logic signed [16:0] r_shr;
    logic signed [7:0]  q_sat;
    logic signed [7:0]  q;

    // 17 bits hold delta plus the rounding constant without overflow
    always_comb begin
        r_sum = $signed({delta[15], delta}) + RND;
        r_shr = r_sum >>> SHIFT;
        if (r_shr > 17'sd127) begin
            q_sat = 8'sd127;
        end else if (r_shr < -17'sd128) begin
            q_sat = -8'sd128;
        end else begin
            q_sat = r_shr[7:0];
        end
    end

    // Optional activation clamp applied after saturation
    always_comb begin
`ifdef MAC_REQUANT_RELU_EN
        q = q_sat[7] ? 8'sd0 : q_sat;
`else
        q = q_sat;
`endif
    end

    // ------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fcnt;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty = (fcnt == '0);
    assign full  = (fcnt == FULL_CNT);
    assign pop   = ~empty & out_ready;
    assign push  = d_vld & (~full | pop);
    assign drop  = d_vld & full & ~pop;

    // Pointers wrap naturally; the occupancy count tells full from empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fcnt <= fcnt + 1'b1;
            end else if (pop && !push) begin
                fcnt <= fcnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q;
        end
    end

    // Sticky drop flag; a same-cycle drop wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_mac_window_requant.sv
// Self-checking bench for mac_window_requant (VEC_LEN=4, SHIFT=4, DEPTH=4).
// Directed table, hand-written corner sequences and a random run vs. a model.
module tb_mac_window_requant;

    localparam int VL = 4;
    localparam int SH = 4;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] acc_in = '0;
    logic        acc_step = 1'b0;
    logic        sync_clr = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] acc = '0;

    mac_window_requant #(.VEC_LEN(VL), .SHIFT(SH), .DEPTH(DP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .acc_in(acc_in),
        .acc_step(acc_step),
        .sync_clr(sync_clr),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAC_REQUANT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Floor division of (sum + half) by 2^SH, then clamp to int8
    function automatic int rq(input logic [15:0] d);
        int s, r, den;
        den = 1 << SH;
        s = int'($signed(d));
        r = s + den / 2;
        if (r >= 0) r = r / den;
        else r = -((-r + den - 1) / den);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return relu(r);
    endfunction

    // ---------------- reference model ----------------
    int          mq[$];
    int          m_cnt = 0;
    logic [15:0] m_base = '0;
    bit          m_pend = 0;
    int          m_pval = 0;
    bit          m_ovf = 0;
    bit          mdl_on = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_cnt = 0;
            m_base = '0;
            m_pend = 0;
            m_ovf = 0;
        end else begin
            bit full, pop, setf;
            full = (mq.size() == DP);
            pop = (mq.size() > 0) && out_ready;
            setf = 0;
            if (pop) void'(mq.pop_front());
            if (m_pend) begin
                if (!full || pop) mq.push_back(m_pval);
                else setf = 1;
            end
            if (setf) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_pend = 0;
            if (sync_clr) begin
                m_cnt = 0;
                m_base = acc_in;
            end else if (acc_step) begin
                m_cnt++;
                if (m_cnt == VL) begin
                    m_pend = 1;
                    m_pval = rq(acc_in - m_base);
                    m_base = acc_in;
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && mdl_on) begin
            chk("mdl_valid", int'(out_valid), int'(mq.size() > 0));
            chk("mdl_data", int'($signed(out_data)),
                (mq.size() > 0) ? mq[0] : 0);
            chk("mdl_ovf", int'(overflow), int'(m_ovf));
        end
    end

    // ---------------- drive helpers ----------------
    task automatic drv(input int inc, input bit st, input bit clr);
        @(negedge clk);
        if (st || clr) acc = acc + 16'(inc);
        acc_in = acc;
        acc_step = st;
        sync_clr = clr;
    endtask

    task automatic idle();
        drv(0, 0, 0);
    endtask

    task automatic window(input int inc);
        for (int k = 0; k < VL; k++) drv(inc, 1, 0);
    endtask

    typedef struct {
        string       nm;
        bit          use_start;
        logic [15:0] start;
        int          inc;
        int          exp;
    } vec_t;

    vec_t tv[8];
    int   ex[$];

    initial begin
        tv[0] = '{"basic",    0, 16'd0,     15,    4};
        tv[1] = '{"rnd_pos",  0, 16'd0,     6,     2};
        tv[2] = '{"rnd_neg",  0, 16'd0,     -6,    -1};
        tv[3] = '{"half_pos", 0, 16'd0,     2,     1};
        tv[4] = '{"half_neg", 0, 16'd0,     -2,    0};
        tv[5] = '{"sat_hi",   0, 16'd0,     8128,  127};
        tv[6] = '{"sat_lo",   0, 16'd0,     -8192, -128};
        tv[7] = '{"wrap",     1, 16'd32000, 500,   125};

        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mdl_on = 1;

        // Directed windows: latency and value
        foreach (tv[i]) begin
            @(negedge clk);
            if (tv[i].use_start) acc = tv[i].start;
            acc_in = acc;
            sync_clr = 1'b1;
            acc_step = 1'b0;
            out_ready = 1'b0;
            window(tv[i].inc);
            idle();
            chk({tv[i].nm, "_t1"}, int'(out_valid), 0);
            idle();
            chk({tv[i].nm, "_t2"}, int'(out_valid), 1);
            chk({tv[i].nm, "_val"}, int'($signed(out_data)),
                relu(tv[i].exp));
            out_ready = 1'b1;
            idle();
            out_ready = 1'b0;
            chk({tv[i].nm, "_pop"}, int'(out_valid), 0);
        end

        // Backpressure: five windows into a four-entry FIFO
        drv(0, 0, 1);
        out_ready = 1'b0;
        ex.delete();
        for (int w = 0; w < 5; w++) begin
            int inc;
            inc = int'($urandom_range(0, 400)) - 200;
            window(inc);
            ex.push_back(rq(16'(inc * VL)));
        end
        idle();
        idle();
        chk("bp_ovf", int'(overflow), 1);
        chk("bp_valid", int'(out_valid), 1);
        for (int i = 0; i < DP; i++) begin
            chk("bp_order", int'($signed(out_data)), ex[i]);
            out_ready = 1'b1;
            idle();
        end
        out_ready = 1'b0;
        chk("bp_drained", int'(out_valid), 0);
        chk("bp_ovf_held", int'(overflow), 1);
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        chk("bp_ovf_clr", int'(overflow), 0);

        // sync_clr mid-window, also asserted with a step
        drv(0, 0, 1);
        drv(100, 1, 0);
        drv(100, 1, 0);
        drv(50, 1, 1);
        window(16);
        idle();
        chk("clr_t1", int'(out_valid), 0);
        idle();
        chk("clr_valid", int'(out_valid), 1);
        chk("clr_val", int'($signed(out_data)), 4);
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        chk("clr_single", int'(out_valid), 0);

        // Reset mid-window with a full FIFO and overflow set
        drv(0, 0, 1);
        for (int w = 0; w < 5; w++) window(16);
        idle();
        idle();
        drv(7, 1, 0);
        drv(7, 1, 0);
        chk("pre_rst_ovf", int'(overflow), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_data", int'(out_data), 0);
        @(negedge clk);
        acc = '0;
        acc_in = '0;
        acc_step = 1'b0;
        reset_n = 1'b1;
        window(16);
        idle();
        chk("rst_t1", int'(out_valid), 0);
        idle();
        chk("rst_restart", int'(out_valid), 1);
        chk("rst_val", int'($signed(out_data)), 4);
        out_ready = 1'b1;
        idle();

        // Random traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            int inc;
            bit st, cl;
            if ($urandom_range(0, 7) == 0)
                inc = int'($urandom_range(0, 65535));
            else
                inc = int'($urandom_range(0, 400)) - 200;
            st = ($urandom_range(0, 1) == 1);
            cl = ($urandom_range(0, 49) == 0);
            drv(inc, st, cl);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovf = ($urandom_range(0, 19) == 0);
        end
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        for (int c = 0; c < 8; c++) idle();
        chk("end_drained", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
